// File: rtl/lr35902_ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lr35902_ppu_pkg
// Description : Shared PPU types and VRAM offset constants for the
//               background tile fetcher and its address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package lr35902_ppu_pkg;

    // Width of a PPU-side VRAM offset (8 KiB window)
    localparam int VADR_W = 13;

    // Tile-map bases and the signed-mode tile-data base
    localparam logic [VADR_W-1:0] MAP0_BASE        = 13'h1800;
    localparam logic [VADR_W-1:0] MAP1_BASE        = 13'h1C00;
    localparam logic [VADR_W-1:0] DATA_SIGNED_BASE = 13'h1000;

    // Fetcher states: one request/data pair per VRAM byte, then the push
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MAP_REQ = 3'd1,
        S_MAP_DAT = 3'd2,
        S_LO_REQ  = 3'd3,
        S_LO_DAT  = 3'd4,
        S_HI_REQ  = 3'd5,
        S_HI_DAT  = 3'd6,
        S_PUSH    = 3'd7
    } fetch_state_t;

endpackage : lr35902_ppu_pkg
`default_nettype wire

// File: rtl/lr35902_bg_adr.sv
`default_nettype none
// ============================================================================
// Module      : lr35902_bg_adr
// Description : Combinational VRAM address generator for the background
//               fetcher: tile-map address from (col, y) and tile-data
//               address from (idx, row, plane).
// Revision    : 1.0 - initial release
// ============================================================================
module lr35902_bg_adr
    import lr35902_ppu_pkg::*;
(
    input  logic [4:0]        i_col,
    input  logic [7:0]        i_y,
    input  logic [7:0]        i_idx,
    input  logic              i_map_sel,
    input  logic              i_data_sel,
    input  logic              i_hi,
    output logic [VADR_W-1:0] o_map_adr,
    output logic [VADR_W-1:0] o_data_adr
);

    logic [VADR_W-1:0] w_map_base;
    logic              w_signed_hi;

    // Map base select; the two bases differ only in bit 10
    assign w_map_base = i_map_sel ? MAP1_BASE : MAP0_BASE;

    // In signed mode, indices 0x00-0x7F live above the 0x1000 base while
    // 0x80-0xFF fold back into the 0x0800 block shared with unsigned mode
    assign w_signed_hi = ~i_data_sel & ~i_idx[7];

    // Address assembly: map row = y/8 (32 tiles per row), data row = y%8
    always_comb begin
        o_map_adr  = w_map_base | {3'b000, i_y[7:3], i_col};
        o_data_adr = ({VADR_W{w_signed_hi}} & DATA_SIGNED_BASE)
                   | {1'b0, i_idx, i_y[2:0], i_hi};
    end

endmodule : lr35902_bg_adr
`default_nettype wire

// File: rtl/lr35902_bg_fetch.sv
`default_nettype none
// ============================================================================
// Module      : lr35902_bg_fetch
// Description : PPU background tile fetcher. Walks one scanline's tiles,
//               reading map byte, low and high tile-data bytes per tile
//               from VRAM, and hands each row pair to the pixel FIFO over
//               a valid/ready handshake. Owns the VRAM port while active.
// Revision    : 1.0 - initial release
// ============================================================================
module lr35902_bg_fetch
    import lr35902_ppu_pkg::*;
#(
    parameter int TILES_PER_LINE = 21
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        scx,
    input  logic [7:0]        scy,
    input  logic [7:0]        ly,
    input  logic              map_sel,
    input  logic              data_sel,
    output logic [VADR_W-1:0] vadr,
    output logic              vread,
    input  logic [7:0]        vdata,
    output logic              ppu_active,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_lo,
    output logic [7:0]        pix_hi,
    output logic              done
);

    localparam int C_N_W = $clog2(TILES_PER_LINE + 1);
    localparam logic [C_N_W-1:0] C_N_LAST = C_N_W'(TILES_PER_LINE - 1);

    fetch_state_t      r_state;
    logic [C_N_W-1:0]  r_n;
    logic [7:0]        r_y;
    logic [4:0]        r_col;
    logic [7:0]        r_idx;
    logic [VADR_W-1:0] r_vadr;
    logic              r_vread;
    logic              r_active;
    logic              r_pix_valid;
    logic [7:0]        r_pix_lo;
    logic [7:0]        r_pix_hi;
    logic              r_done;

    logic [7:0]        w_y_start;
    logic [4:0]        w_col_start;
    logic [7:0]        w_adr_y;
    logic [4:0]        w_adr_col;
    logic [7:0]        w_adr_idx;
    logic              w_adr_hi;
    logic              w_xfer;
    logic [VADR_W-1:0] w_map_adr;
    logic [VADR_W-1:0] w_data_adr;

    assign w_y_start   = scy + ly;
    assign w_col_start = scx[7:3];
    assign w_xfer      = r_pix_valid & pix_ready;

    // Address-generator operands: on start use the live inputs so the
    // first map request goes out with freshly latched values; otherwise
    // the next map read is for the following column. The tile index comes
    // straight from vdata while it is being captured, else from the latch.
    always_comb begin
        w_adr_y   = start ? w_y_start   : r_y;
        w_adr_col = start ? w_col_start : (r_col + 5'd1);
        w_adr_idx = (r_state == S_MAP_DAT) ? vdata : r_idx;
        w_adr_hi  = (r_state == S_LO_DAT);
    end

    lr35902_bg_adr u_adr (
        .i_col      (w_adr_col),
        .i_y        (w_adr_y),
        .i_idx      (w_adr_idx),
        .i_map_sel  (map_sel),
        .i_data_sel (data_sel),
        .i_hi       (w_adr_hi),
        .o_map_adr  (w_map_adr),
        .o_data_adr (w_data_adr)
    );

    // Fetch sequencer with registered VRAM strobe, FIFO handshake and done
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_y         <= '0;
            r_col       <= '0;
            r_idx       <= '0;
            r_vadr      <= '0;
            r_vread     <= 1'b0;
            r_active    <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_lo    <= '0;
            r_pix_hi    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // Abort wins over start and drops everything at once
                r_state     <= S_IDLE;
                r_vread     <= 1'b0;
                r_active    <= 1'b0;
                r_pix_valid <= 1'b0;
            end else if (start) begin
                // Start (or restart mid-line) from tile 0 with new scroll/line
                r_state     <= S_MAP_REQ;
                r_n         <= '0;
                r_y         <= w_y_start;
                r_col       <= w_col_start;
                r_vadr      <= w_map_adr;
                r_vread     <= 1'b1;
                r_active    <= 1'b1;
                r_pix_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_vread <= 1'b0;
                    end
                    S_MAP_REQ: begin
                        r_vread <= 1'b0;
                        r_state <= S_MAP_DAT;
                    end
                    S_MAP_DAT: begin
                        r_idx   <= vdata;
                        r_vadr  <= w_data_adr;
                        r_vread <= 1'b1;
                        r_state <= S_LO_REQ;
                    end
                    S_LO_REQ: begin
                        r_vread <= 1'b0;
                        r_state <= S_LO_DAT;
                    end
                    S_LO_DAT: begin
                        r_pix_lo <= vdata;
                        r_vadr   <= w_data_adr;
                        r_vread  <= 1'b1;
                        r_state  <= S_HI_REQ;
                    end
                    S_HI_REQ: begin
                        r_vread <= 1'b0;
                        r_state <= S_HI_DAT;
                    end
                    S_HI_DAT: begin
                        r_pix_hi    <= vdata;
                        r_pix_valid <= 1'b1;
                        r_state     <= S_PUSH;
                    end
                    S_PUSH: begin
                        // Stall here with no VRAM traffic until the FIFO takes it
                        if (w_xfer) begin
                            r_pix_valid <= 1'b0;
                            if (r_n == C_N_LAST) begin
                                r_state  <= S_IDLE;
                                r_active <= 1'b0;
                                r_done   <= 1'b1;
                            end else begin
                                r_n     <= r_n + 1'b1;
                                r_col   <= r_col + 5'd1;
                                r_vadr  <= w_map_adr;
                                r_vread <= 1'b1;
                                r_state <= S_MAP_REQ;
                            end
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_vread     <= 1'b0;
                        r_active    <= 1'b0;
                        r_pix_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign vadr       = r_vadr;
    assign vread      = r_vread;
    assign ppu_active = r_active;
    assign pix_valid  = r_pix_valid;
    assign pix_lo     = r_pix_lo;
    assign pix_hi     = r_pix_hi;
    assign done       = r_done;

endmodule : lr35902_bg_fetch
`default_nettype wire

// File: tb/tb_lr35902_bg_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lr35902_bg_fetch
// Description : Directed self-checking bench for the background fetcher
//               with a 1-cycle-latency VRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lr35902_bg_fetch;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  scx = 8'h00;
    logic [7:0]  scy = 8'h00;
    logic [7:0]  ly = 8'h00;
    logic        map_sel = 1'b0;
    logic        data_sel = 1'b1;
    logic [12:0] vadr;
    logic        vread;
    logic [7:0]  vdata = 8'h00;
    logic        ppu_active;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix_lo;
    logic [7:0]  pix_hi;
    logic        done;

    logic [7:0]  mem [0:8191];
    logic [12:0] rd_q [$];
    logic [7:0]  lo_q [$];
    logic [7:0]  hi_q [$];
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    lr35902_bg_fetch #(.TILES_PER_LINE(21)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .abort      (abort),
        .scx        (scx),
        .scy        (scy),
        .ly         (ly),
        .map_sel    (map_sel),
        .data_sel   (data_sel),
        .vadr       (vadr),
        .vread      (vread),
        .vdata      (vdata),
        .ppu_active (ppu_active),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_lo     (pix_lo),
        .pix_hi     (pix_hi),
        .done       (done)
    );

    // VRAM model: read strobe at a clock edge loads dout for the next cycle
    always @(posedge clk) begin
        if (vread) vdata <= mem[vadr];
    end

    // Bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (vread) rd_q.push_back(vadr);
        if (pix_valid && pix_ready) begin
            xfer_cnt++;
            lo_q.push_back(pix_lo);
            hi_q.push_back(pix_hi);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        lo_q.delete();
        hi_q.delete();
        xfer_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt, 1);
    endtask

    initial begin
        int hold_bad;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h1800] = 8'h05;
        mem[13'h0050] = 8'hAA;
        mem[13'h0051] = 8'h55;

        // Reset state
        repeat (3) tick();
        check("rst_vadr", vadr, 0);
        check("rst_vread", vread, 0);
        check("rst_active", ppu_active, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_pix", {pix_lo, pix_hi}, 0);
        check("rst_done", done, 0);
        nreset = 1'b1;
        tick();

        // Basic fetch
        clear_mon();
        do_start();
        check("t1_vread_e0", vread, 1);
        check("t1_vadr_e0", vadr, 13'h1800);
        check("t1_active", ppu_active, 1);
        repeat (5) tick();
        check("t1_valid_e5", pix_valid, 0);
        tick();
        check("t1_valid_e6", pix_valid, 1);
        check("t1_lo", pix_lo, 8'hAA);
        check("t1_hi", pix_hi, 8'h55);
        check("t1_nrd", rd_q.size(), 3);
        check("t1_rd0", rd_q[0], 13'h1800);
        check("t1_rd1", rd_q[1], 13'h0050);
        check("t1_rd2", rd_q[2], 13'h0051);
        wait_done(300);
        tick();
        check("t1_xfers", xfer_cnt, 21);
        check("t1_idle", ppu_active, 0);

        // Column wrap and tile count
        clear_mon();
        scx = 8'hF8;
        do_start();
        wait_done(300);
        repeat (5) tick();
        check("t2_rd0", rd_q[0], 13'h181F);
        check("t2_rd3", rd_q[3], 13'h1800);
        check("t2_rd6", rd_q[6], 13'h1801);
        check("t2_nrd", rd_q.size(), 63);
        check("t2_xfers", xfer_cnt, 21);
        check("t2_done_once", done_cnt, 1);

        // Signed tile-data mode
        clear_mon();
        scx = 8'h00; scy = 8'h00; ly = 8'd3; data_sel = 1'b0;
        mem[13'h1800] = 8'h80;
        mem[13'h1801] = 8'h7F;
        do_start();
        wait_done(300);
        check("t3_rd1", rd_q[1], 13'h0806);
        check("t3_rd2", rd_q[2], 13'h0807);
        check("t3_rd3", rd_q[3], 13'h1801);
        check("t3_rd4", rd_q[4], 13'h17F6);
        check("t3_rd5", rd_q[5], 13'h17F7);

        // Y wrap, map select, mid-line scroll change ignored
        clear_mon();
        scx = 8'h00; scy = 8'hFE; ly = 8'd3; map_sel = 1'b1; data_sel = 1'b1;
        mem[13'h1C00] = 8'h12;
        mem[13'h0122] = 8'h3C;
        mem[13'h0123] = 8'hC3;
        do_start();
        scx = 8'h80; scy = 8'h40; ly = 8'h20;
        wait_done(300);
        check("t4_rd0", rd_q[0], 13'h1C00);
        check("t4_rd1", rd_q[1], 13'h0122);
        check("t4_rd2", rd_q[2], 13'h0123);
        check("t4_rd3", rd_q[3], 13'h1C01);
        check("t4_lo", lo_q[0], 8'h3C);
        check("t4_hi", hi_q[0], 8'hC3);

        // Backpressure
        clear_mon();
        scx = 8'h00; scy = 8'h00; ly = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
        mem[13'h1800] = 8'h05;
        pix_ready = 1'b0;
        do_start();
        repeat (6) tick();
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!pix_valid || vread || pix_lo !== 8'hAA || pix_hi !== 8'h55) hold_bad++;
            tick();
        end
        check("t5_hold", hold_bad, 0);
        check("t5_nrd", rd_q.size(), 3);
        check("t5_noxfer", xfer_cnt, 0);
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        check("t5_one_xfer", xfer_cnt, 1);
        check("t5_next_rd", vread, 1);
        check("t5_next_adr", vadr, 13'h1801);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_idle", ppu_active, 0);
        pix_ready = 1'b1;

        // Abort during LO_DAT, and abort beating start
        clear_mon();
        do_start();
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_active", ppu_active, 0);
        check("t6_vread", vread, 0);
        check("t6_valid", pix_valid, 0);
        repeat (10) tick();
        check("t6_nodone", done_cnt, 0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t6_abort_prio", ppu_active, 0);

        // Asynchronous reset in HI_REQ, then a clean line
        clear_mon();
        do_start();
        repeat (4) tick();
        check("t7_hireq_vread", vread, 1);
        #2 nreset = 1'b0;
        #1;
        check("t7_async_vread", vread, 0);
        check("t7_async_active", ppu_active, 0);
        tick();
        nreset = 1'b1;
        tick();
        clear_mon();
        do_start();
        check("t7_restart_adr", vadr, 13'h1800);
        wait_done(300);
        check("t7_xfers", xfer_cnt, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lr35902_bg_fetch
`default_nettype wire
